// File: rtl/axi3_sram_slave.sv
// axi3_sram_slave: AXI3 responder backed by a dual-port word memory
// (one synchronous read port, one byte-enabled write port).
// Read and write channels run independently, one outstanding burst each.
// Optional build macro: AXI_SLV_DECERR_EN. When defined, bursts starting
// outside [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS) answer DECERR with no memory
// access. When undefined, upper address bits are ignored.
//
// state   | meaning
// R_IDLE  | waiting for AR, arready high
// R_FETCH | one-cycle synchronous memory read of the current beat
// R_DATA  | rvalid high, beat held stable until rready
// W_IDLE  | waiting for AW, awready high, W held off
// W_DATA  | accepting W beats, wready high
// W_RESP  | bvalid high until bready
module axi3_sram_slave #(
    parameter int unsigned ID_W      = 4,
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h1C00_0000
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [ID_W-1:0] arid,
    input  logic [31:0]     araddr,
    input  logic [7:0]      arlen,
    input  logic [1:0]      arburst,
    input  logic            arvalid,
    output logic            arready,
    output logic [ID_W-1:0] rid,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [7:0]      awlen,
    input  logic [1:0]      awburst,
    input  logic            awvalid,
    output logic            awready,
    input  logic [ID_W-1:0] wid,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready
);
    localparam int unsigned IDX_W       = $clog2(MEM_WORDS);
    localparam logic [1:0]  RESP_OKAY   = 2'd0;
    localparam logic [1:0]  RESP_SLVERR = 2'd2;
    localparam logic [1:0]  RESP_DECERR = 2'd3;

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    logic [31:0] mem [MEM_WORDS];

    rstate_t     rstate, rnext;
    logic [31:0] raddr;
    logic [7:0]  rlen, rcnt;
    logic [1:0]  rburst;
    logic        rdecerr;

    wstate_t     wstate, wnext;
    logic [31:0] waddr;
    logic [7:0]  wlen, wcnt;
    logic [1:0]  wburst;
    logic        werr, wdecerr;
    logic        w_beat, w_final, w_bad, mem_we;
    logic        ar_oor, aw_oor;

    // Beat size is always 4 bytes; WRAP only wraps for 2/4/8/16-beat bursts,
    // everything else (including burst type 3) advances like INCR.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [7:0]  len,
                                              input logic [1:0]  burst);
        logic [31:0] inc;
        logic [31:0] mask;
        inc  = addr + 32'd4;
        mask = (({24'd0, len} + 32'd1) << 2) - 32'd1;
        if (burst == 2'd0)
            return addr;
        if (burst == 2'd2 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            return (addr & ~mask) | (inc & mask);
        return inc;
    endfunction

`ifdef AXI_SLV_DECERR_EN
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + ({1'b0, 32'(MEM_WORDS)} << 2);
    assign ar_oor = ({1'b0, araddr} < WIN_LO) || ({1'b0, araddr} >= WIN_HI);
    assign aw_oor = ({1'b0, awaddr} < WIN_LO) || ({1'b0, awaddr} >= WIN_HI);
`else
    assign ar_oor = 1'b0;
    assign aw_oor = 1'b0;
`endif

    assign rvalid = (rstate == R_DATA);

    // Read FSM state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rstate <= R_IDLE;
        else          rstate <= rnext;
    end

    // Read FSM next state
    always_comb begin
        rnext = rstate;
        case (rstate)
            R_IDLE:  if (arvalid && arready) rnext = R_FETCH;
            R_FETCH: rnext = R_DATA;
            R_DATA:  if (rready) rnext = rlast ? R_IDLE : R_FETCH;
            default: rnext = R_IDLE;
        endcase
    end

    // Read datapath: latch AR, fetch one word per beat, hold beat until accepted
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arready <= 1'b0;
            rid     <= '0;
            raddr   <= '0;
            rlen    <= '0;
            rburst  <= '0;
            rcnt    <= '0;
            rdecerr <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rlast   <= 1'b0;
        end else begin
            arready <= (rnext == R_IDLE);
            case (rstate)
                R_IDLE: if (arvalid && arready) begin
                    rid     <= arid;
                    raddr   <= araddr;
                    rlen    <= arlen;
                    rburst  <= arburst;
                    rcnt    <= 8'd0;
                    rdecerr <= ar_oor;
                end
                R_FETCH: begin
                    rdata <= rdecerr ? 32'd0 : mem[raddr[IDX_W+1:2]];
                    rresp <= rdecerr ? RESP_DECERR : RESP_OKAY;
                    rlast <= (rcnt == rlen);
                end
                R_DATA: if (rready && !rlast) begin
                    raddr <= next_addr(raddr, rlen, rburst);
                    rcnt  <= rcnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign wready  = (wstate == W_DATA);
    assign bvalid  = (wstate == W_RESP);
    assign w_beat  = wvalid && wready;
    assign w_final = (wcnt == wlen);
    assign w_bad   = (wid != bid) || (wlast != w_final);
    assign mem_we  = w_beat && !w_bad && !werr && !wdecerr;

    // Write FSM state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) wstate <= W_IDLE;
        else          wstate <= wnext;
    end

    // Write FSM next state; the beat count, not wlast, ends the burst
    always_comb begin
        wnext = wstate;
        case (wstate)
            W_IDLE: if (awvalid && awready) wnext = W_DATA;
            W_DATA: if (w_beat && w_final) wnext = W_RESP;
            W_RESP: if (bready) wnext = W_IDLE;
            default: wnext = W_IDLE;
        endcase
    end

    // Write datapath: latch AW, advance per beat, accumulate protocol errors
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awready <= 1'b0;
            bid     <= '0;
            bresp   <= RESP_OKAY;
            waddr   <= '0;
            wlen    <= '0;
            wburst  <= '0;
            wcnt    <= '0;
            werr    <= 1'b0;
            wdecerr <= 1'b0;
        end else begin
            awready <= (wnext == W_IDLE);
            case (wstate)
                W_IDLE: if (awvalid && awready) begin
                    bid     <= awid;
                    waddr   <= awaddr;
                    wlen    <= awlen;
                    wburst  <= awburst;
                    wcnt    <= 8'd0;
                    werr    <= 1'b0;
                    wdecerr <= aw_oor;
                end
                W_DATA: if (w_beat) begin
                    waddr <= next_addr(waddr, wlen, wburst);
                    wcnt  <= wcnt + 8'd1;
                    werr  <= werr | w_bad;
                    if (w_final)
                        bresp <= wdecerr ? RESP_DECERR :
                                 (werr || w_bad) ? RESP_SLVERR : RESP_OKAY;
                end
                default: ;
            endcase
        end
    end

    // Memory write port; contents survive reset
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++)
                if (wstrb[i]) mem[waddr[IDX_W+1:2]][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_axi3_sram_slave.sv
// tb_axi3_sram_slave: directed bench for axi3_sram_slave with a read-beat
// scoreboard and a reference word memory.
module tb_axi3_sram_slave;
    localparam int          ID_W = 4;
    localparam logic [31:0] BASE = 32'h1C00_0000;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [ID_W-1:0] arid = '0;
    logic [31:0]     araddr = '0;
    logic [7:0]      arlen = '0;
    logic [1:0]      arburst = '0;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready = 1'b0;
    logic [ID_W-1:0] awid = '0;
    logic [31:0]     awaddr = '0;
    logic [7:0]      awlen = '0;
    logic [1:0]      awburst = '0;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [ID_W-1:0] wid = '0;
    logic [31:0]     wdata = '0;
    logic [3:0]      wstrb = '0;
    logic            wlast = 1'b0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b0;

    axi3_sram_slave dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0]     data;
        logic [1:0]      resp;
        logic            last;
        logic [ID_W-1:0] id;
    } rbeat_t;

    rbeat_t      rq[$];
    logic [1:0]  bq[$];
    logic [31:0] model [4096];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input logic [1:0] burst, input int i);
        logic [31:0] a, sz, base;
        a  = start & ~32'h3;
        sz = 32'((len + 1) * 4);
        if (burst == 2'd0) return a;
        if (burst == 2'd2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            base = a - (a % sz);
            return base + ((a - base + 32'(4 * i)) % sz);
        end
        return a + 32'(4 * i);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[13:2]);
    endfunction

    function automatic logic oor(input logic [31:0] a);
        logic en;
`ifdef AXI_SLV_DECERR_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        return en && ((a < BASE) || (a >= BASE + 32'h0000_4000));
    endfunction

    task automatic axi_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input int last_at, input logic [ID_W-1:0] wid_v);
        int          g;
        logic        err;
        logic [31:0] a;
        err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            err = err | (wid_v != id) | ((i == last_at) != (i == len));
            a = beat_addr(addr, len, burst, i);
            if (!err && !oor(addr))
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) model[widx(a)][8*b +: 8] = wd[i][8*b +: 8];
        end
        bq.push_back(oor(addr) ? 2'd3 : (err ? 2'd2 : 2'd0));
        awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
        g = 0;
        while (!awready && g < 50) begin @(negedge aclk); g++; end
        chk("aw_ready", awready, 1);
        @(posedge aclk); @(negedge aclk);
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wid = wid_v; wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_at); wvalid = 1'b1;
            g = 0;
            while (!wready && g < 50) begin @(negedge aclk); g++; end
            chk("w_ready", wready, 1);
            @(posedge aclk); @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        g = 0;
        while (!bvalid && g < 50) begin @(negedge aclk); g++; end
        chk("b_valid", bvalid, 1);
        chk("bresp", bresp, bq.pop_front());
        chk("bid", bid, id);
        @(posedge aclk); @(negedge aclk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input int stall_beat, input int stall_n);
        rbeat_t      e;
        int          g, beats, hs_cyc;
        logic [31:0] sd;
        logic        sl;
        for (int i = 0; i <= len; i++) begin
            e.data = oor(addr) ? 32'd0 : model[widx(beat_addr(addr, len, burst, i))];
            e.resp = oor(addr) ? 2'd3 : 2'd0;
            e.last = (i == len);
            e.id   = id;
            rq.push_back(e);
        end
        arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arvalid = 1'b1;
        g = 0;
        while (!arready && g < 50) begin @(negedge aclk); g++; end
        chk("ar_ready", arready, 1);
        hs_cyc = cyc;
        @(posedge aclk); @(negedge aclk);
        arvalid = 1'b0; rready = 1'b1;
        beats = 0; g = 0;
        while (beats <= len && g < 200) begin
            if (rvalid) begin
                if (beats == 0) chk("r_latency", 32'(cyc - hs_cyc), 2);
                if (beats == stall_beat) begin
                    rready = 1'b0; sd = rdata; sl = rlast;
                    repeat (stall_n) @(negedge aclk);
                    chk("stall_rvalid", rvalid, 1);
                    chk("stall_rdata", rdata, sd);
                    chk("stall_rlast", rlast, sl);
                    rready = 1'b1;
                end
                e = rq.pop_front();
                chk("rdata", rdata, e.data);
                chk("rresp", rresp, e.resp);
                chk("rlast", rlast, e.last);
                chk("rid", rid, e.id);
                beats++;
                @(posedge aclk);
            end
            @(negedge aclk);
            g++;
        end
        chk("r_beats", beats, len + 1);
        rq.delete();
        rready = 1'b0;
    endtask

    initial begin
        int g;
        repeat (3) @(negedge aclk);
        chk("rst_arready", arready, 0);
        chk("rst_awready", awready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ids", {rid, bid}, 0);
        chk("rst_resp_last", {rresp, bresp, rlast}, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("idle_arready", arready, 1);
        chk("idle_awready", awready, 1);
        chk("idle_wready", wready, 0);

        // single beat write then read
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        axi_write(4'h3, BASE + 32'h4, 0, 2'd1, 0, 4'h3);
        axi_read(4'h3, BASE + 32'h4, 0, 2'd1, -1, 0);

        // INCR 4 beats
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        axi_write(4'h2, BASE + 32'h10, 3, 2'd1, 3, 4'h2);
        axi_read(4'h5, BASE + 32'h10, 3, 2'd1, -1, 0);

        // WRAP 4 beats starting mid-window: 0x18,0x1C,0x10,0x14
        axi_read(4'h6, BASE + 32'h18, 3, 2'd2, -1, 0);

        // partial byte write
        wd[0] = 32'hAABB_CCDD; ws[0] = 4'hF;
        axi_write(4'h1, BASE + 32'h40, 0, 2'd1, 0, 4'h1);
        wd[0] = 32'h0000_0011; ws[0] = 4'h1;
        axi_write(4'h1, BASE + 32'h40, 0, 2'd1, 0, 4'h1);
        chk("partial_model", model[widx(BASE + 32'h40)], 32'hAABB_CC11);
        axi_read(4'h1, BASE + 32'h40, 0, 2'd1, -1, 0);

        // 8-beat burst, read back with a 5-cycle stall on beat 2
        for (int i = 0; i < 8; i++) begin wd[i] = 32'hC0DE_0000 + 32'(i * 17); ws[i] = 4'hF; end
        axi_write(4'h7, BASE + 32'h80, 7, 2'd1, 7, 4'h7);
        axi_read(4'h7, BASE + 32'h80, 7, 2'd1, 2, 5);

        // burst type 3 and non-power-of-two WRAP both advance like INCR
        axi_read(4'h8, BASE + 32'h80, 1, 2'd3, -1, 0);
        axi_read(4'h9, BASE + 32'h84, 2, 2'd2, -1, 0);

        // FIXED burst: every beat hits the same word
        wd[0] = 32'h1111_0000; wd[1] = 32'h2222_0000; wd[2] = 32'h3333_0000;
        axi_write(4'hA, BASE + 32'h100, 2, 2'd0, 2, 4'hA);
        axi_read(4'hA, BASE + 32'h100, 2, 2'd0, -1, 0);

        // protocol errors: early wlast, then wid mismatch
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA000_0000 + 32'(i); ws[i] = 4'hF; end
        axi_write(4'h4, BASE + 32'h200, 3, 2'd1, 3, 4'h4);
        for (int i = 0; i < 4; i++) wd[i] = 32'hB000_0000 + 32'(i);
        axi_write(4'h4, BASE + 32'h200, 3, 2'd1, 2, 4'h4);
        wd[0] = 32'hC000_0000; wd[1] = 32'hC000_0001;
        axi_write(4'h4, BASE + 32'h208, 1, 2'd1, 1, 4'hB);
        axi_read(4'h4, BASE + 32'h200, 3, 2'd1, -1, 0);

        // reset in the middle of a read burst
        arid = 4'h1; araddr = BASE + 32'h80; arlen = 8'd3; arburst = 2'd1; arvalid = 1'b1;
        g = 0;
        while (!arready && g < 50) begin @(negedge aclk); g++; end
        chk("rst_ar_ready", arready, 1);
        @(posedge aclk); @(negedge aclk);
        arvalid = 1'b0;
        g = 0;
        while (!rvalid && g < 20) begin @(negedge aclk); g++; end
        chk("rst_pre_rvalid", rvalid, 1);
        #1 aresetn = 1'b0;
        #1;
        chk("rst_abort_rvalid", rvalid, 0);
        chk("rst_abort_rdata", rdata, 0);
        chk("rst_abort_arready", arready, 0);
        @(negedge aclk); aresetn = 1'b1;
        @(negedge aclk);
        axi_read(4'h1, BASE + 32'h80, 3, 2'd1, -1, 0);

`ifdef AXI_SLV_DECERR_EN
        wd[0] = 32'h5555_AAAA; wd[1] = 32'h6666_BBBB; ws[0] = 4'hF; ws[1] = 4'hF;
        axi_write(4'h2, 32'h0000_0000, 1, 2'd1, 1, 4'h2);
        axi_read(4'h2, 32'h0000_0000, 1, 2'd1, -1, 0);
        axi_read(4'h2, BASE + 32'h4, 0, 2'd1, -1, 0);
`else
        wd[0] = 32'h5555_AAAA; ws[0] = 4'hF;
        axi_write(4'h2, 32'h0000_0300, 0, 2'd1, 0, 4'h2);
        chk("alias_model", model[widx(BASE + 32'h300)], 32'h5555_AAAA);
        axi_read(4'h2, BASE + 32'h300, 0, 2'd1, -1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
